// File: rtl/conv_bn_relu_new_pkg.sv
// rtl/conv_bn_relu_new_pkg.sv - shared constants, state encoding and width helper for conv_bn_relu_new
package conv_bn_relu_new_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int FRAC_BITS       = 16;
    localparam int IMAGE_WIDTH     = 612;
    localparam int IMAGE_HEIGHT    = 612;
    localparam int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CHANNEL_NUM_OUT = 64;
    localparam int PIX_CNT_W       = $clog2(IMAGE_SIZE);
    localparam int COEF_CNT_W      = $clog2(2 * CHANNEL_NUM_OUT);

    // Upper clamp of the ReLU6 variant, in integer units before the Q shift.
    localparam int RELU6_VALUE = 6;
    localparam logic [DATA_WIDTH-1:0] RELU6_LIMIT = DATA_WIDTH'(RELU6_VALUE) << FRAC_BITS;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_bn_coef_ram_new.sv
// rtl/conv_bn_coef_ram_new.sv - gamma/beta register file, one write port, one paired read port
module conv_bn_coef_ram_new #(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int ADDR_W          = 7,
    parameter int CH_W            = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [CH_W-1:0]       rch_i,
    output logic [DATA_WIDTH-1:0] gamma_o,
    output logic [DATA_WIDTH-1:0] beta_o
);

    logic [DATA_WIDTH-1:0] mem_q [2*CHANNEL_NUM_OUT];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Even slots hold gamma, odd slots beta, matching the interleaved load order.
    assign gamma_o = mem_q[{rch_i, 1'b0}];
    assign beta_o  = mem_q[{rch_i, 1'b1}];

endmodule

// File: rtl/conv_bn_relu_new.sv
// rtl/conv_bn_relu_new.sv - per-channel affine + ReLU, 3-cycle pipeline; CONV_BN_RELU6_EN adds a 6.0 clamp
module conv_bn_relu_new #(
    parameter int DATA_WIDTH      = conv_bn_relu_new_pkg::DATA_WIDTH,
    parameter int FRAC_BITS       = conv_bn_relu_new_pkg::FRAC_BITS,
    parameter int IMAGE_WIDTH     = conv_bn_relu_new_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT    = conv_bn_relu_new_pkg::IMAGE_HEIGHT,
    parameter int CHANNEL_NUM_OUT = conv_bn_relu_new_pkg::CHANNEL_NUM_OUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  coef_ready
);
    import conv_bn_relu_new_pkg::*;

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PIX_W      = cnt_w(IMAGE_SIZE);
    localparam int CH_W       = cnt_w(CHANNEL_NUM_OUT);
    localparam int COEF_W     = cnt_w(2 * CHANNEL_NUM_OUT);
    localparam int PROD_W     = 2 * DATA_WIDTH;
    localparam int SUM_W      = 2 * DATA_WIDTH + 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [COEF_W-1:0] COEF_LAST = COEF_W'(2 * CHANNEL_NUM_OUT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

    state_e              state_q, state_d;
    logic [COEF_W-1:0]   coef_cnt_q, coef_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic                coef_ready_q, coef_ready_d;
    logic                coef_we;
    logic                pix_accept;

    logic [DATA_WIDTH-1:0] ram_gamma, ram_beta;

    logic                         s1_valid_q;
    logic signed [DATA_WIDTH-1:0] s1_pxl_q, s1_gamma_q, s1_beta_q;
    logic                         s2_valid_q;
    logic signed [PROD_W-1:0]     s2_prod_q;
    logic signed [DATA_WIDTH-1:0] s2_beta_q;
    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0]        relu;
    logic [DATA_WIDTH-1:0]        act;
    logic                         valid_out_q;
    logic [DATA_WIDTH-1:0]        pxl_out_q;

    conv_bn_coef_ram_new #(
        .DATA_WIDTH      (DATA_WIDTH),
        .CHANNEL_NUM_OUT (CHANNEL_NUM_OUT),
        .ADDR_W          (COEF_W),
        .CH_W            (CH_W)
    ) u_coef_ram (
        .clk     (clk),
        .we_i    (coef_we),
        .waddr_i (coef_cnt_q),
        .wdata_i (weight_in),
        .rch_i   (ch_cnt_q),
        .gamma_o (ram_gamma),
        .beta_o  (ram_beta)
    );

    always_comb begin
        state_d      = state_q;
        coef_cnt_d   = coef_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        coef_ready_d = coef_ready_q;
        coef_we      = 1'b0;
        pix_accept   = 1'b0;
        case (state_q)
            LOAD: begin
                if (valid_weight_in) begin
                    coef_we    = 1'b1;
                    coef_cnt_d = coef_cnt_q + 1'b1;
                    if (coef_cnt_q == COEF_LAST) begin
                        coef_cnt_d   = '0;
                        state_d      = RUN;
                        coef_ready_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (valid_in) begin
                    pix_accept = 1'b1;
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Both operands are sign-extended to the full product width before multiplying.
    assign prod = PROD_W'(s1_gamma_q) * PROD_W'(s1_pxl_q);

    // Saturation to the signed range folds into ReLU: anything negative is already 0.
    always_comb begin
        sum = SUM_W'(s2_prod_q) + SUM_W'(s2_beta_q);
        if (sum[SUM_W-1]) begin
            relu = '0;
        end else if (sum > SAT_MAX) begin
            relu = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else begin
            relu = sum[DATA_WIDTH-1:0];
        end
    end

`ifdef CONV_BN_RELU6_EN
    localparam logic [DATA_WIDTH-1:0] RELU6_LIM = DATA_WIDTH'(RELU6_VALUE) << FRAC_BITS;
    assign act = (relu > RELU6_LIM) ? RELU6_LIM : relu;
`else
    assign act = relu;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            coef_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            coef_ready_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            valid_out_q  <= 1'b0;
            pxl_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            coef_cnt_q   <= coef_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            coef_ready_q <= coef_ready_d;
            s1_valid_q   <= pix_accept;
            s2_valid_q   <= s1_valid_q;
            valid_out_q  <= s2_valid_q;
            if (s2_valid_q) begin
                pxl_out_q <= act;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_accept) begin
            s1_pxl_q   <= pxl_in;
            s1_gamma_q <= ram_gamma;
            s1_beta_q  <= ram_beta;
        end
        if (s1_valid_q) begin
            s2_prod_q <= prod >>> FRAC_BITS;
            s2_beta_q <= s1_beta_q;
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign coef_ready = coef_ready_q;

endmodule

// File: tb/tb_conv_bn_relu_new.sv
// tb/tb_conv_bn_relu_new.sv - table-driven and scoreboard bench for conv_bn_relu_new
module tb_conv_bn_relu_new;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic          valid_weight_in = 1'b0;
    logic [DW-1:0] weight_in = '0;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          coef_ready;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_out = 0;

    typedef struct {
        logic [DW-1:0] exp;
        int            cyc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic [DW-1:0] x;
        logic [DW-1:0] exp;
        logic [DW-1:0] exp6;
        string         name;
    } vec_t;
    vec_t vecs[10];

    conv_bn_relu_new #(
        .DATA_WIDTH      (DW),
        .FRAC_BITS       (8),
        .IMAGE_WIDTH     (2),
        .IMAGE_HEIGHT    (2),
        .CHANNEL_NUM_OUT (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .pxl_in          (pxl_in),
        .valid_weight_in (valid_weight_in),
        .weight_in       (weight_in),
        .pxl_out         (pxl_out),
        .valid_out       (valid_out),
        .coef_ready      (coef_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            sb_t e;
            n_out++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got valid_out with pxl_out=%h at cycle %0d, required no output", pxl_out, cyc);
            end else begin
                e = sb_q.pop_front();
                if (pxl_out !== e.exp || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_check: got %h at cycle %0d, required %h at cycle %0d", pxl_out, cyc, e.exp, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] x, input logic wv,
                        input logic [DW-1:0] w, input logic push, input logic [DW-1:0] e);
        valid_in        = v;
        pxl_in          = x;
        valid_weight_in = wv;
        weight_in       = w;
        if (push) sb_q.push_back('{exp: e, cyc: cyc + 3});
        @(posedge clk);
        #1;
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] g0, input logic [DW-1:0] b0,
                        input logic [DW-1:0] g1, input logic [DW-1:0] b1);
        step(1'b0, '0, 1'b1, g0, 1'b0, '0);
        step(1'b0, '0, 1'b1, b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, g1, 1'b0, '0);
        check("coef_ready_after_3", {15'd0, coef_ready}, 16'd0);
        step(1'b0, '0, 1'b1, b1, 1'b0, '0);
        check("coef_ready_after_4", {15'd0, coef_ready}, 16'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [DW-1:0] e;
        int base;

        vecs[0] = '{16'h0100, 16'h0080, 16'h0200, 16'h0280, 16'h0280, "unit_gain"};
        vecs[1] = '{16'h0100, 16'hFF00, 16'h0080, 16'h0000, 16'h0000, "relu_clip"};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0600, "sat_pos"};
        vecs[3] = '{16'h0100, 16'h0000, 16'h0800, 16'h0800, 16'h0600, "relu6_stim"};
        vecs[4] = '{16'hFFFF, 16'h0002, 16'h0001, 16'h0001, 16'h0001, "trunc_floor"};
        vecs[5] = '{16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0600, "sat_negneg"};
        vecs[6] = '{16'h0180, 16'h0040, 16'h0100, 16'h01C0, 16'h01C0, "frac_gain"};
        vecs[7] = '{16'h0100, 16'h0000, 16'h0601, 16'h0601, 16'h0600, "six_plus"};
        vecs[8] = '{16'h0100, 16'h0000, 16'h0600, 16'h0600, 16'h0600, "six_exact"};
        vecs[9] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0100, 16'h0100, "neg_x"};

        repeat (2) @(posedge clk);
        #1;
        check("reset_pxl_out", pxl_out, 16'h0000);
        check("reset_valid_out", {15'd0, valid_out}, 16'd0);
        check("reset_coef_ready", {15'd0, coef_ready}, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_reset();
            load(vecs[i].g, vecs[i].b, 16'h0100, 16'h0000);
`ifdef CONV_BN_RELU6_EN
            e = vecs[i].exp6;
`else
            e = vecs[i].exp;
`endif
            step(1'b1, vecs[i].x, 1'b0, '0, 1'b1, e);
            drain();
        end

        // Channel sequencing with gaps, frame wrap, and a weight word ignored in RUN.
        do_reset();
        load(16'h0100, 16'h0010, 16'h0200, 16'h0020);
        for (int i = 0; i < 9; i++) begin
            e = (i >= 4 && i < 8) ? 16'h0220 : 16'h0110;
            step(1'b1, 16'h0100, (i == 2 || i == 5), 16'hDEAD, 1'b1, e);
            if (i % 3 == 1) idle(1);
        end
        drain();

        // Pixels during LOAD, including alongside the final coefficient, are dropped.
        do_reset();
        base = n_out;
        step(1'b1, 16'h0100, 1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 16'h0100, 1'b0, '0);
        step(1'b1, 16'h0100, 1'b1, 16'h0000, 1'b0, '0);
        step(1'b0, '0, 1'b1, 16'h0100, 1'b0, '0);
        step(1'b1, 16'h0200, 1'b1, 16'h0000, 1'b0, '0);
        check("coef_ready_manual_load", {15'd0, coef_ready}, 16'd1);
        idle(5);
        check("load_discard_count", 16'(n_out - base), 16'd0);
        step(1'b1, 16'h0300, 1'b0, '0, 1'b1, 16'h0300);
        drain();

        // Reset with two pixels in flight.
        base = n_out;
        step(1'b1, 16'h0100, 1'b0, '0, 1'b0, '0);
        step(1'b1, 16'h0100, 1'b0, '0, 1'b0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_valid_out", {15'd0, valid_out}, 16'd0);
        check("midreset_coef_ready", {15'd0, coef_ready}, 16'd0);
        reset = 1'b0;
        idle(2);
        step(1'b1, 16'h0100, 1'b0, '0, 1'b0, '0);
        idle(5);
        check("midreset_no_output", 16'(n_out - base), 16'd0);
        check("midreset_still_load", {15'd0, coef_ready}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_bn_relu_new.md
Name: conv_bn_relu_new

Overview:
- Streaming per-channel affine (folded batch-norm) plus ReLU stage. Sits directly downstream of the 3x3 conv layer wrappers and consumes the channel-summed output of the 64-channel adder.
- Computes y = ReLU(x*gamma[c] + beta[c]) in signed fixed point, one pixel per cycle.
- Before any pixel is processed, per-output-channel coefficients are loaded serially through the weight port.

Parameters:
- DATA_WIDTH, 32, width of pixels and coefficients; signed two's complement.
- FRAC_BITS, 16, fractional bits of pixels and coefficients (Q format).
- IMAGE_WIDTH, 612, pixels per row.
- IMAGE_HEIGHT, 612, rows per channel plane.
- CHANNEL_NUM_OUT, 64, number of channel planes per frame; also the number of gamma/beta pairs.
- IMAGE_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, pixels per channel plane.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- valid_in  input  1  pxl_in is valid this cycle.
- pxl_in  input  DATA_WIDTH  conv/adder output pixel; channel-planar order (all IMAGE_SIZE pixels of channel 0, then channel 1, and so on).
- valid_weight_in  input  1  weight_in is valid this cycle.
- weight_in  input  DATA_WIDTH  coefficient word.
- pxl_out  output  DATA_WIDTH  activated pixel.
- valid_out  output  1  pxl_out is valid.
- coef_ready  output  1  high once all coefficients are loaded.

Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset values: pxl_out=0, valid_out=0, coef_ready=0. State goes to LOAD; coefficient and pixel counters go to 0; pipeline valids are cleared. Coefficient RAM contents are not cleared.
- FSM state LOAD:
  - Each valid_weight_in writes weight_in to coefficient slot coef_cnt; coef_cnt increments.
  - Order is interleaved: gamma[0], beta[0], gamma[1], beta[1], ... for 2*CHANNEL_NUM_OUT words.
  - The write of word 2*CHANNEL_NUM_OUT-1 moves the FSM to RUN; coef_ready rises the next cycle.
  - valid_in pulses in LOAD are discarded and produce no output.
- FSM state RUN:
  - valid_weight_in is ignored.
  - Each valid_in advances pix_cnt (0..IMAGE_SIZE-1). On wrap, ch_cnt advances (0..CHANNEL_NUM_OUT-1).
  - After the final pixel of the final channel, both counters wrap to 0 and the FSM stays in RUN, so coefficients are reused for the next frame.
  - The only way back to LOAD is reset.
- Pipeline: fixed 3-cycle latency from valid_in to valid_out; no backpressure; gaps in valid_in are preserved one-for-one.
  - Stage 1: register pxl_in and read gamma/beta for ch_cnt. Coefficients are selected by the channel of the incoming pixel, not the counter value after the increment.
  - Stage 2: signed product of width 2*DATA_WIDTH, arithmetic right shift by FRAC_BITS (truncation toward minus infinity).
  - Stage 3: add sign-extended beta, saturate to signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], apply ReLU (negative becomes 0), register to pxl_out.
- pxl_out holds its last value when valid_out=0.
- Reset mid-stream: in-flight pipeline valids are dropped, and valid_out is 0 on the cycle after reset is sampled.
- Simultaneous valid_in and valid_weight_in in RUN: the pixel is processed and the weight is ignored.
- valid_in on the same cycle as the last coefficient write: the pixel is discarded, because the state is still LOAD.

Optional Feature:
- Macro: CONV_BN_RELU6_EN.
- Defined: after ReLU, the output is clamped to 6.0, i.e. min(y, 6<<FRAC_BITS). Latency is unchanged.
- Undefined: plain ReLU with no upper clamp; the only upper bound is saturation.

Decomposition:
- Shared package/include holds the constants: DATA_WIDTH, FRAC_BITS, IMAGE_SIZE, CHANNEL_NUM_OUT, the counter widths as clog2 of IMAGE_SIZE and 2*CHANNEL_NUM_OUT, the FSM state encodings (LOAD=1'b0, RUN=1'b1) and the RELU6 limit constant.
- One natural sub-module: conv_bn_coef_ram_new, a 2*CHANNEL_NUM_OUT x DATA_WIDTH register file with one write port and one read port returning the gamma/beta pair.

Test Plan:
- Common setup for all tests: DATA_WIDTH=16, FRAC_BITS=8, IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM_OUT=2.
- Load gamma0=0x0100, beta0=0x0080; feed x=0x0200 -> pxl_out=0x0280 exactly 3 cycles later; coef_ready=1 after the 4th weight word.
- Load gamma0=0x0100, beta0=0xFF00 (-1.0); feed x=0x0080 -> pxl_out=0x0000 (ReLU clips -0.5).
- Load gamma0=0x7FFF, beta0=0x7FFF; feed x=0x7FFF -> pxl_out=0x7FFF (saturation).
- Load gamma1=0x0200; feed 4 pixels of 0x0100 then 4 more -> first 4 outputs use channel 0 coefficients, next 4 output 0x0200 (+beta1); a 9th pixel uses channel 0 again (frame wrap).
- Feed valid_in before loading completes -> no valid_out. Assert reset with 2 pixels in flight -> valid_out=0 from the next cycle; coef_ready=0 and state is LOAD.
- With CONV_BN_RELU6_EN: gamma=0x0100, beta=0, x=0x0800 -> pxl_out=0x0600. Without the macro, the same stimulus -> pxl_out=0x0800.
